dout_display: RTL and testbench



---
 rtl/display_pkg.sv | 21 ++
 rtl/seg_encoder.sv | 27 ++
 rtl/dout_display.sv | 98 +++++++++
 tb/tb_dout_display.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared FSM encoding, segment codes and BCD helpers
// for the dout_display seven-segment path.
package display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
    localparam int BCD_W = 12;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction
endpackage

// File: rtl/seg_encoder.sv
// seg_encoder: BCD digit plus blank flag to active-low seven-segment pattern.
module seg_encoder
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/dout_display.sv
// dout_display: samples the SoC dout bus while dval is high, converts it to
// decimal with a sequential double dabble and drives four seven-segment digits.
module dout_display
    import display_pkg::*;
#(
    parameter bit SIGNED        = 1'b0,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] din,
    input  logic       dval,
    output logic       busy,
    output logic       shown,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);
    state_t           r_state, w_next;
    logic [7:0]       r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [2:0]       r_cnt;
    logic             r_neg, r_shown;
    logic [6:0]       r_hex0, r_hex1, r_hex2, r_hex3;
    logic             w_neg, w_blank1, w_blank2;
    logic [7:0]       w_mag;
    logic [BCD_W-1:0] w_adj;
    logic [6:0]       w_seg0, w_seg1, w_seg2, w_seg3;

    assign w_neg    = SIGNED && din[7];
    assign w_mag    = w_neg ? 8'(~din + 8'd1) : din;
    assign w_adj    = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    assign w_blank2 = BLANK_LEADING && (r_bcd[11:8] == 4'd0);
    assign w_blank1 = w_blank2 && (r_bcd[7:4] == 4'd0);
    assign w_seg3   = r_neg ? SEG_MINUS : (BLANK_LEADING || SIGNED) ? SEG_BLANK : SEG_0;

    seg_encoder u_enc0 (.i_bcd(r_bcd[3:0]),  .i_blank(1'b0),     .o_seg(w_seg0));
    seg_encoder u_enc1 (.i_bcd(r_bcd[7:4]),  .i_blank(w_blank1), .o_seg(w_seg1));
    seg_encoder u_enc2 (.i_bcd(r_bcd[11:8]), .i_blank(w_blank2), .o_seg(w_seg2));

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = dval ? SHIFT : IDLE;
            SHIFT:   w_next = (r_cnt == 3'd7) ? LOAD : SHIFT;
            LOAD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Hex outputs are only written in LOAD, so partial BCD never reaches the pins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_shown <= 1'b0;
            r_hex0  <= SEG_BLANK;
            r_hex1  <= SEG_BLANK;
            r_hex2  <= SEG_BLANK;
            r_hex3  <= SEG_BLANK;
        end else begin
            case (r_state)
                IDLE: if (dval) begin
                    r_bin <= w_mag;
                    r_neg <= w_neg;
                    r_bcd <= '0;
                    r_cnt <= '0;
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 3'd1;
                end
                LOAD: begin
                    r_hex0  <= w_seg0;
                    r_hex1  <= w_seg1;
                    r_hex2  <= w_seg2;
                    r_hex3  <= w_seg3;
                    r_shown <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign shown = r_shown;
    assign hex0  = r_hex0;
    assign hex1  = r_hex1;
    assign hex2  = r_hex2;
    assign hex3  = r_hex3;
endmodule

// File: tb/tb_dout_display.sv
// tb_dout_display: table-driven checks of three parameter variants plus
// hand-written latency, ignore-while-busy and async-reset sequences.
module tb_dout_display;
    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [7:0]      din = '0;
    logic            dval = 1'b0;
    logic [2:0]      busy, shown;
    logic [2:0][6:0] h0, h1, h2, h3;
    int              n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    dout_display #(.SIGNED(1'b0), .BLANK_LEADING(1'b1)) u_d0 (.clk(clk), .resetn(resetn), .din(din), .dval(dval),
        .busy(busy[0]), .shown(shown[0]), .hex0(h0[0]), .hex1(h1[0]), .hex2(h2[0]), .hex3(h3[0]));
    dout_display #(.SIGNED(1'b0), .BLANK_LEADING(1'b0)) u_d1 (.clk(clk), .resetn(resetn), .din(din), .dval(dval),
        .busy(busy[1]), .shown(shown[1]), .hex0(h0[1]), .hex1(h1[1]), .hex2(h2[1]), .hex3(h3[1]));
    dout_display #(.SIGNED(1'b1), .BLANK_LEADING(1'b1)) u_d2 (.clk(clk), .resetn(resetn), .din(din), .dval(dval),
        .busy(busy[2]), .shown(shown[2]), .hex0(h0[2]), .hex1(h1[2]), .hex2(h2[2]), .hex3(h3[2]));

    typedef struct {
        int         d;
        logic [7:0] din;
        logic [6:0] e3, e2, e1, e0;
    } vec_t;
    vec_t vt[15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_hex(input string name, input int d, input logic [6:0] e3, e2, e1, e0);
        chk({name, " hex3"}, {1'b0, h3[d]}, {1'b0, e3});
        chk({name, " hex2"}, {1'b0, h2[d]}, {1'b0, e2});
        chk({name, " hex1"}, {1'b0, h1[d]}, {1'b0, e1});
        chk({name, " hex0"}, {1'b0, h0[d]}, {1'b0, e0});
    endtask

    // One-cycle dval pulse; returns #1 after the edge where the new value is visible.
    task automatic convert(input logic [7:0] v);
        @(negedge clk);
        din  = v;
        dval = 1'b1;
        @(posedge clk);
        #1 dval = 1'b0;
        repeat (9) @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int nb;
        vt[0]  = '{0, 8'd0,   7'h7F, 7'h7F, 7'h7F, 7'h40};
        vt[1]  = '{0, 8'd255, 7'h7F, 7'h24, 7'h12, 7'h12};
        vt[2]  = '{0, 8'd105, 7'h7F, 7'h79, 7'h40, 7'h12};
        vt[3]  = '{0, 8'd10,  7'h7F, 7'h7F, 7'h79, 7'h40};
        vt[4]  = '{0, 8'd186, 7'h7F, 7'h79, 7'h00, 7'h02};
        vt[5]  = '{0, 8'd43,  7'h7F, 7'h7F, 7'h19, 7'h30};
        vt[6]  = '{1, 8'd7,   7'h40, 7'h40, 7'h40, 7'h78};
        vt[7]  = '{1, 8'd255, 7'h40, 7'h24, 7'h12, 7'h12};
        vt[8]  = '{1, 8'd0,   7'h40, 7'h40, 7'h40, 7'h40};
        vt[9]  = '{2, 8'h80,  7'h3F, 7'h79, 7'h24, 7'h00};
        vt[10] = '{2, 8'hFF,  7'h3F, 7'h7F, 7'h7F, 7'h79};
        vt[11] = '{2, 8'h7F,  7'h7F, 7'h79, 7'h24, 7'h78};
        vt[12] = '{2, 8'h00,  7'h7F, 7'h7F, 7'h7F, 7'h40};
        vt[13] = '{2, 8'hF6,  7'h3F, 7'h7F, 7'h79, 7'h40};
        vt[14] = '{2, 8'h63,  7'h7F, 7'h7F, 7'h10, 7'h10};

        // reset state, held for 100 cycles with dval low
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 3'b000 || shown !== 3'b000 || h0[0] !== 7'h7F || h1[0] !== 7'h7F ||
                h2[0] !== 7'h7F || h3[0] !== 7'h7F || h3[1] !== 7'h7F || h0[2] !== 7'h7F) ok = 1'b0;
        end
        chk("reset hold 100 cycles", {7'd0, ok}, 8'd1);

        // first conversion: busy width, latency, shown
        @(negedge clk);
        din  = 8'd0;
        dval = 1'b1;
        @(posedge clk);
        #1 dval = 1'b0;
        nb = 0;
        for (int k = 0; k < 20 && busy[0]; k++) begin
            nb++;
            if (k == 8) begin
                chk("no early update hex0", {1'b0, h0[0]}, 8'h7F);
                chk("shown before load", {7'd0, shown[0]}, 8'd0);
            end
            @(posedge clk);
            #1;
        end
        chk("busy cycles", 8'(nb), 8'd9);
        chk("shown after load", {7'd0, shown[0]}, 8'd1);
        chk_hex("first din=0", 0, 7'h7F, 7'h7F, 7'h7F, 7'h40);

        for (int i = 0; i < 15; i++) begin
            convert(vt[i].din);
            chk_hex($sformatf("vec%0d d%0d din=%h", i, vt[i].d, vt[i].din), vt[i].d,
                    vt[i].e3, vt[i].e2, vt[i].e1, vt[i].e0);
        end

        // din change during SHIFT ignored; dval low afterwards keeps 12
        @(negedge clk);
        din  = 8'd12;
        dval = 1'b1;
        @(posedge clk);
        #1 dval = 1'b0;
        repeat (3) @(posedge clk);
        #1 din = 8'd99;
        repeat (6) @(posedge clk);
        #1 chk_hex("busy change dval low", 0, 7'h7F, 7'h7F, 7'h79, 7'h24);
        repeat (20) @(posedge clk);
        #1 chk_hex("hold with dval low", 0, 7'h7F, 7'h7F, 7'h79, 7'h24);

        // held-high dval: 12 first, then 99 on the resample ten edges later
        @(negedge clk);
        din  = 8'd12;
        dval = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 din = 8'd99;
        repeat (6) @(posedge clk);
        #1 chk_hex("held dval first", 0, 7'h7F, 7'h7F, 7'h79, 7'h24);
        chk("held dval recapture busy", {7'd0, busy[0]}, 8'd0);
        repeat (10) @(posedge clk);
        #1 chk_hex("held dval second", 0, 7'h7F, 7'h7F, 7'h10, 7'h10);
        dval = 1'b0;

        // async reset during SHIFT, no stale load after release
        @(negedge clk);
        din  = 8'd255;
        dval = 1'b1;
        @(posedge clk);
        #1 dval = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async reset busy", {7'd0, busy[0]}, 8'd0);
        chk("async reset shown", {7'd0, shown[0]}, 8'd0);
        chk_hex("async reset", 0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("post reset busy", {7'd0, busy[0]}, 8'd0);
        chk("post reset shown", {7'd0, shown[0]}, 8'd0);
        chk_hex("post reset", 0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
